// File: rtl/axis_frame_rx.sv
// axis_frame_rx: AXI-Stream sink that checks frame length against ITERATION, forwards beats, counts frames and errors.
// Latency: an accepted beat appears on out_* one cycle after the accepting edge; counters and done update in step.
// Backpressure: axis_tready = enable && LFSR stall gate (never from tvalid); the output side cannot stall.
module axis_frame_rx #(
   parameter int          BITWIDTH    = 32,
   parameter int          ITERATION   = 64,
   parameter int          FRAMES      = 16,
   parameter int          STALL_SHIFT = 0,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                axis_tvalid,
   output logic                axis_tready,
   input  logic [BITWIDTH-1:0] axis_tdata,
   input  logic                axis_tlast,
   output logic                out_valid,
   output logic [BITWIDTH-1:0] out_data,
   output logic                out_last,
   output logic [31:0]         frame_ok,
   output logic [31:0]         err_short,
   output logic [31:0]         err_long,
   output logic                done
);

   localparam int               IDX_W    = (ITERATION > 1) ? $clog2(ITERATION) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATION - 1);
   localparam logic [31:0]      FRAMES_W = 32'(FRAMES);

   typedef enum logic {RECV, DRAIN} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic             stall_ok;
   logic             accept;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Stall gate: a zero shift disables backpressure entirely.
   generate
      if (STALL_SHIFT == 0) begin : g_no_stall
         assign stall_ok = 1'b1;
      end else begin : g_stall
         assign stall_ok = (lfsr[STALL_SHIFT-1:0] != '0);
      end
   endgenerate

   // Ready depends only on registered state and enable, so it is valid during reset too.
   assign axis_tready = enable && stall_ok;
   assign accept      = axis_tvalid && axis_tready;

   // Free-running Fibonacci LFSR (taps 16,14,13,11), advances every cycle out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   // Frame FSM: length check, registered forwarding and counters on each accepted beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RECV;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         frame_ok  <= '0;
         err_short <= '0;
         err_long  <= '0;
         done      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         if (accept) begin
            case (state)
               RECV: begin
                  out_valid <= 1'b1;
                  out_data  <= axis_tdata;
                  if (axis_tlast) begin
                     out_last <= 1'b1;
                     idx      <= '0;
                     if (idx == LAST_IDX) begin
                        frame_ok <= frame_ok + 32'd1;
                        if (frame_ok + 32'd1 == FRAMES_W) begin
                           done <= 1'b1;
                        end
                     end else begin
                        err_short <= err_short + 32'd1;
                     end
                  end else if (idx == LAST_IDX) begin
                     // Frame overran: close it downstream and discard the rest up to tlast.
                     out_last <= 1'b1;
                     err_long <= err_long + 32'd1;
                     state    <= DRAIN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               DRAIN: begin
                  if (axis_tlast) begin
                     idx   <= '0;
                     state <= RECV;
                  end
               end
               default: state <= RECV;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_rx.sv
// tb_axis_frame_rx: directed scoreboard bench for axis_frame_rx.
// Instance a: ITERATION=4, FRAMES=2, no stall. Instance b: STALL_SHIFT=2 with an LFSR reference.
// Stimulus pushes expected beats into queues; one negedge monitor pops and compares.
module tb_axis_frame_rx;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
      logic [31:0]  due;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] cyc = 32'd0;
   always @(posedge clock) cyc <= cyc + 32'd1;

   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   // Instance a signals
   logic         reset_a = 1'b1, enable_a = 1'b1, tvalid_a = 1'b0, tlast_a = 1'b0;
   logic [W-1:0] tdata_a = '0;
   logic         tready_a, out_valid_a, out_last_a, done_a;
   logic [W-1:0] out_data_a;
   logic [31:0]  frame_ok_a, err_short_a, err_long_a;

   // Instance b signals
   logic         reset_b = 1'b1, enable_b = 1'b1, tvalid_b = 1'b0, tlast_b = 1'b0;
   logic [W-1:0] tdata_b = '0;
   logic         tready_b, out_valid_b, out_last_b, done_b;
   logic [W-1:0] out_data_b;
   logic [31:0]  frame_ok_b, err_short_b, err_long_b;

   axis_frame_rx #(.BITWIDTH(W), .ITERATION(4), .FRAMES(2), .STALL_SHIFT(0), .SEED(16'hACE1)) dut_a (
      .clock(clock), .reset(reset_a), .enable(enable_a),
      .axis_tvalid(tvalid_a), .axis_tready(tready_a), .axis_tdata(tdata_a), .axis_tlast(tlast_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a),
      .frame_ok(frame_ok_a), .err_short(err_short_a), .err_long(err_long_a), .done(done_a)
   );

   axis_frame_rx #(.BITWIDTH(W), .ITERATION(4), .FRAMES(1000), .STALL_SHIFT(2), .SEED(16'hACE1)) dut_b (
      .clock(clock), .reset(reset_b), .enable(enable_b),
      .axis_tvalid(tvalid_b), .axis_tready(tready_b), .axis_tdata(tdata_b), .axis_tlast(tlast_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
      .frame_ok(frame_ok_b), .err_short(err_short_b), .err_long(err_long_b), .done(done_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every forwarded beat must match the head of its queue, on the cycle predicted.
   always @(negedge clock) begin
      exp_t e;
      if (out_valid_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_beat: got data %0h expected no beat", out_data_a);
         end else begin
            e = q_a.pop_front();
            chk("a_data", out_data_a, e.data);
            chk("a_last", {31'd0, out_last_a}, {31'd0, e.last});
            chk("a_latency", cyc, e.due);
         end
      end
      if (out_valid_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_beat: got data %0h expected no beat", out_data_b);
         end else begin
            e = q_b.pop_front();
            chk("b_data", out_data_b, e.data);
            chk("b_last", {31'd0, out_last_b}, {31'd0, e.last});
            chk("b_latency", cyc, e.due);
         end
      end
   end

   // Present one beat to instance a and hold it until accepted (bounded wait).
   task automatic send_a(input logic [W-1:0] d, input logic l, input logic fwd, input logic elast);
      int n;
      n = 0;
      @(negedge clock);
      tvalid_a = 1'b1;
      tdata_a  = d;
      tlast_a  = l;
      #1;
      while (!tready_a && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL a_send_timeout: got no tready expected tready within 50 cycles");
      end else if (fwd) begin
         q_a.push_back('{d, elast, cyc + 32'd1});
      end
      @(posedge clock);
      #1;
      tvalid_a = 1'b0;
   endtask

   // Send a well-formed 4-beat frame starting at base.
   task automatic frame_a(input logic [W-1:0] base);
      for (int i = 0; i < 4; i++) begin
         send_a(base + W'(i), (i == 3), 1'b1, (i == 3));
      end
   endtask

   task automatic pulse_reset_a();
      @(negedge clock);
      reset_a  = 1'b1;
      tvalid_a = 1'b0;
      repeat (2) @(negedge clock);
      reset_a = 1'b0;
   endtask

   task automatic chk_ctrs_a(input string tag, input logic [31:0] fok, input logic [31:0] es,
                             input logic [31:0] el, input logic dn);
      @(negedge clock);
      #1;
      chk({tag, "_frame_ok"}, frame_ok_a, fok);
      chk({tag, "_err_short"}, err_short_a, es);
      chk({tag, "_err_long"}, err_long_a, el);
      chk({tag, "_done"}, {31'd0, done_a}, {31'd0, dn});
   endtask

   task automatic chk_reset_a(input string tag);
      #1;
      chk({tag, "_out_valid"}, {31'd0, out_valid_a}, 32'd0);
      chk({tag, "_out_data"}, out_data_a, 32'd0);
      chk({tag, "_out_last"}, {31'd0, out_last_a}, 32'd0);
      chk({tag, "_frame_ok"}, frame_ok_a, 32'd0);
      chk({tag, "_err_short"}, err_short_a, 32'd0);
      chk({tag, "_err_long"}, err_long_a, 32'd0);
      chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
   endtask

   initial begin
      logic [15:0] lfsr_model;
      logic [31:0] cnt;
      int          stalls;
      logic        exp_rdy;

      // Reset state; ready follows enable while in reset.
      repeat (2) @(negedge clock);
      #1;
      chk("a_tready_in_reset", {31'd0, tready_a}, 32'd1);
      chk("b_tready_in_reset", {31'd0, tready_b}, 32'd1);
      chk_reset_a("a_rst");
      @(negedge clock);
      reset_a = 1'b0;

      // Two good frames back to back; done rises only with the second.
      frame_a(32'h100);
      chk_ctrs_a("t1_f1", 32'd1, 32'd0, 32'd0, 1'b0);
      frame_a(32'h104);
      chk_ctrs_a("t1_f2", 32'd2, 32'd0, 32'd0, 1'b1);

      // Short frame: tlast on the third beat, then a good frame.
      pulse_reset_a();
      send_a(32'h200, 1'b0, 1'b1, 1'b0);
      send_a(32'h201, 1'b0, 1'b1, 1'b0);
      send_a(32'h202, 1'b1, 1'b1, 1'b1);
      chk_ctrs_a("t2_short", 32'd0, 32'd1, 32'd0, 1'b0);
      frame_a(32'h210);
      chk_ctrs_a("t2_after", 32'd1, 32'd1, 32'd0, 1'b0);

      // Long frame: 6 beats, beat 4 forced last, beats 5-6 dropped.
      pulse_reset_a();
      send_a(32'h300, 1'b0, 1'b1, 1'b0);
      send_a(32'h301, 1'b0, 1'b1, 1'b0);
      send_a(32'h302, 1'b0, 1'b1, 1'b0);
      send_a(32'h303, 1'b0, 1'b1, 1'b1);
      send_a(32'h304, 1'b0, 1'b0, 1'b0);
      send_a(32'h305, 1'b1, 1'b0, 1'b0);
      chk_ctrs_a("t3_long", 32'd0, 32'd0, 32'd1, 1'b0);
      frame_a(32'h310);
      chk_ctrs_a("t3_after", 32'd1, 32'd0, 32'd1, 1'b0);

      // Enable low for 5 cycles mid-frame with a beat pending.
      pulse_reset_a();
      send_a(32'h400, 1'b0, 1'b1, 1'b0);
      send_a(32'h401, 1'b0, 1'b1, 1'b0);
      @(negedge clock);
      enable_a = 1'b0;
      tvalid_a = 1'b1;
      tdata_a  = 32'h4FF;
      tlast_a  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_tready_disabled", {31'd0, tready_a}, 32'd0);
         @(negedge clock);
      end
      enable_a = 1'b1;
      tvalid_a = 1'b0;
      send_a(32'h402, 1'b0, 1'b1, 1'b0);
      send_a(32'h403, 1'b1, 1'b1, 1'b1);
      chk_ctrs_a("t4_enable", 32'd1, 32'd0, 32'd0, 1'b0);

      // Reset mid-frame with a beat offered during reset; the next frame starts at beat 0.
      pulse_reset_a();
      send_a(32'h500, 1'b0, 1'b1, 1'b0);
      send_a(32'h501, 1'b0, 1'b1, 1'b0);
      @(negedge clock);
      reset_a  = 1'b1;
      tvalid_a = 1'b1;
      tdata_a  = 32'h5FF;
      tlast_a  = 1'b0;
      repeat (2) @(negedge clock);
      tvalid_a = 1'b0;
      reset_a  = 1'b0;
      chk_reset_a("t5_rst");
      frame_a(32'h510);
      chk_ctrs_a("t5_after", 32'd1, 32'd0, 32'd0, 1'b0);

      // LFSR backpressure on instance b with tvalid held high.
      @(negedge clock);
      reset_b    = 1'b0;
      tvalid_b   = 1'b1;
      lfsr_model = 16'hACE1;
      cnt        = 32'd0;
      stalls     = 0;
      for (int i = 0; i < 1000; i++) begin
         tdata_b = cnt;
         tlast_b = (cnt[1:0] == 2'd3);
         #1;
         exp_rdy = (lfsr_model[1:0] != 2'b00);
         chk("b_tready_lfsr", {31'd0, tready_b}, {31'd0, exp_rdy});
         if (exp_rdy) begin
            q_b.push_back('{cnt, (cnt[1:0] == 2'd3), cyc + 32'd1});
            cnt = cnt + 32'd1;
         end else begin
            stalls++;
         end
         @(posedge clock);
         lfsr_model = {lfsr_model[14:0],
                       lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
         @(negedge clock);
      end
      tvalid_b = 1'b0;
      checks++;
      if (stalls < 150 || stalls > 350) begin
         errors++;
         $display("FAIL b_stall_ratio: got %0d stalls expected 150..350 of 1000", stalls);
      end
      repeat (3) @(negedge clock);
      #1;
      chk("b_frame_ok", frame_ok_b, cnt >> 2);
      chk("b_err_short", err_short_b, 32'd0);
      chk("b_err_long", err_long_b, 32'd0);
      chk("a_queue_drained", q_a.size(), 32'd0);
      chk("b_queue_drained", q_b.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case stimulus stalls somewhere unforeseen.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
